// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO.
// The serial line is synchronized, decoded by a small FSM that samples
// mid-bit, and each good byte is pushed into the FIFO. Overflow and
// framing errors are reported as sticky flags cleared by clr_err.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 78,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic [7:0]                    rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  // Terminal counts: a full bit period and the half period to mid-start-bit.
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic          sync1, rx_s;
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          push_req, frame_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, full, push_ok, ovf_set;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  // Next-state decode: mid-bit sampling, byte push and framing errors.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF_BIT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_BIT) begin
          cnt_d            = '0;
          shreg_d[bit_idx] = rx_s;
          bit_idx_d        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_BIT) begin
          cnt_d = '0;
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            // Bad stop bit: drop the byte and wait out any break condition.
            frame_set = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO handshake: a pop frees a slot in the same cycle, so push while full
  // succeeds when the consumer is also popping.
  assign rvalid  = (count != '0);
  assign rdata   = mem[rptr];
  assign pop     = rvalid && rready;
  assign full    = (count == DEPTH);
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // observable through rvalid, which is forced low by resetting count.
    if (push_ok) mem[wptr] <= shreg;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with 8 clocks per bit and a 4-entry FIFO.
// Stimulus is driven on the falling edge; outputs are sampled on it too.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic [2:0] count;
  logic       overflow;
  logic       frame_err;
  logic       clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // One 8N1 frame; optionally strobe rready or clr_err for exactly the
  // clock edge on which the receiver samples the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic rdy_at_stop, input logic clr_at_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    uart_rx = stop;
    repeat (CPB - 2) @(negedge clk);
    rready  = rdy_at_stop;
    clr_err = clr_at_stop;
    @(negedge clk);
    rready  = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid: got %b want 1", rvalid); end
    n_checks++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL single_rdata: got %h want a5", rdata); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    pop_one();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_pop_rvalid: got %b want 0", rvalid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_pop_count: got %0d want 0", count); end
    // A pop request on an empty FIFO must not underflow the count.
    pop_one();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (rvalid !== 1'b1 || rdata !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_pop%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", i, rvalid, rdata, 8'(i));
      end
      pop_one();
    end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got rvalid=%b want 0", rvalid); end
    pulse_clr();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    for (int i = 1; i <= 4; i++) send_frame(8'hB0 + 8'(i), 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    send_frame(8'hB5, 1'b1, 1'b1, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want 4", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf: got %b want 0", overflow); end
    for (int i = 2; i <= 5; i++) begin
      n_checks++; if (rvalid !== 1'b1 || rdata !== 8'hB0 + 8'(i)) begin
        n_fail++; $display("FAIL full_pop%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", i, rvalid, rdata, 8'hB0 + 8'(i));
      end
      pop_one();
    end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", count); end
  endtask

  task automatic test_glitch();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd1 || rdata !== 8'h5A) begin
      n_fail++; $display("FAIL glitch_recover: got count=%0d rdata=%h want count=1 rdata=5a", count, rdata);
    end
    pop_one();
  endtask

  task automatic test_frame_err();
    // clr_err coincides with the framing error: the set must win.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ferr_count: got %0d want 0", count); end
    pulse_clr();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd1 || rdata !== 8'h3C || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL ferr_recover: got count=%0d rdata=%h ferr=%b want 1 3c 0", count, rdata, frame_err);
    end
    pop_one();
  endtask

  task automatic test_break();
    uart_rx = 1'b0;
    repeat (120) @(negedge clk);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b want 1", frame_err); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL break_count: got %0d want 0", count); end
    // Clear while the line is still low: no second error may appear.
    pulse_clr();
    repeat (40) @(negedge clk);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL break_single_event: got %b want 0", frame_err); end
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (count !== 3'd0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL break_release: got count=%0d ferr=%b want 0 0", count, frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (count !== 3'd1 || frame_err !== 1'b1) begin
      n_fail++; $display("FAIL prereset: got count=%0d ferr=%b want 1 1", count, frame_err);
    end
    // Start 0x77 and reset after three data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    n_checks++; if (count !== 3'd0 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_count: got count=%0d rvalid=%b want 0 0", count, rvalid);
    end
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL midreset_after_count: got %0d want 1", count); end
    n_checks++; if (rdata !== 8'h11) begin n_fail++; $display("FAIL midreset_after_rdata: got %h want 11", rdata); end
    n_checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags: got ovf=%b ferr=%b want 0 0", overflow, frame_err);
    end
  endtask

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    rready  = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
